// File: rtl/mssd_frame_gen_pkg.sv
// Shared definitions for the MSSD frame generator: default field widths, idle line level and
// the FSM state type.
package mssd_frame_gen_pkg;

  localparam int unsigned DefPortW = 2;
  localparam int unsigned DefLenW  = 4;
  localparam int unsigned DefDataW = (1 << DefLenW) - 1;

  localparam logic IdleLevel = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StPort  = 3'd2,
    StLen   = 3'd3,
    StData  = 3'd4,
    StGap   = 3'd5
  } state_e;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mssd_frame_gen_if.sv
// Request/serial-line bundle between the frame generator and its driver (switches or harness).
interface mssd_frame_gen_if #(
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DATA_W = 15
);
  logic              bit_en;
  logic              start;
  logic [PORT_W-1:0] port_sel;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] payload;
  logic              ser_out;
  logic              ready;
  logic              busy;
  logic              frame_done;

  modport master (
    output bit_en, start, port_sel, len, payload,
    input  ser_out, ready, busy, frame_done
  );

  modport slave (
    input  bit_en, start, port_sel, len, payload,
    output ser_out, ready, busy, frame_done
  );
endinterface

// File: rtl/mssd_frame_gen_piso.sv
// Loadable parallel-in serial-out register; o_bit is the LSB, shifting moves the next bit down.
module mssd_frame_gen_piso #(
  parameter int unsigned Width = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_data,
  input  logic             i_shift,
  output logic             o_bit
);

  logic [Width-1:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {1'b0, r_sr[Width-1:1]};
    end
  end

  assign o_bit = r_sr[0];

endmodule

// File: rtl/mssd_frame_gen.sv
// Serialises one MSSD frame (start '0', port, length, payload, gap '1') onto the receiver's
// SerIn line, advancing one bit per bit_en strobe.
module mssd_frame_gen
  import mssd_frame_gen_pkg::*;
#(
  parameter int unsigned PORT_W = DefPortW,
  parameter int unsigned LEN_W  = DefLenW,
  parameter int unsigned DATA_W = DefDataW
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mssd_frame_gen_if.slave  bus
);

  localparam int unsigned CntW = max_w(PORT_W, LEN_W);
  localparam int unsigned HdrW = PORT_W + LEN_W;

  localparam logic [CntW-1:0]  PortLast = CntW'(PORT_W - 1);
  localparam logic [CntW-1:0]  LenLast  = CntW'(LEN_W - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [LEN_W-1:0] LenOne   = LEN_W'(1);

  state_e            r_state, w_state_d;
  logic              r_ser, w_ser_d;
  logic              r_busy, w_busy_d;
  logic              r_ready, w_ready_d;
  logic              r_done, w_done_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [HdrW-1:0]   r_hdr, w_hdr_d;
  logic [LEN_W-1:0]  r_len, w_len_d;
  logic              w_piso_load;
  logic              w_piso_shift;
  logic              w_piso_bit;
  logic              w_hdr_msb;

  assign w_hdr_msb = r_hdr[HdrW-1];

  mssd_frame_gen_piso #(
    .Width (DATA_W)
  ) u_piso (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_piso_load),
    .i_data  (bus.payload),
    .i_shift (w_piso_shift),
    .o_bit   (w_piso_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ser   <= IdleLevel;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ser   <= w_ser_d;
      r_busy  <= w_busy_d;
      r_ready <= w_ready_d;
      r_done  <= w_done_d;
      r_cnt   <= w_cnt_d;
      r_hdr   <= w_hdr_d;
      r_len   <= w_len_d;
    end
  end

  // Port and length go out MSB first from one shared header shifter; r_cnt marks the field
  // boundary and later counts remaining payload bits.
  always_comb begin
    w_state_d    = r_state;
    w_ser_d      = r_ser;
    w_busy_d     = r_busy;
    w_ready_d    = r_ready;
    w_done_d     = 1'b0;
    w_cnt_d      = r_cnt;
    w_hdr_d      = r_hdr;
    w_len_d      = r_len;
    w_piso_load  = 1'b0;
    w_piso_shift = 1'b0;

    unique case (r_state)
      StIdle: begin
        // A coincident bit_en is deliberately ignored so the start bit lasts a full period.
        if (bus.start && r_ready) begin
          w_state_d   = StStart;
          w_ser_d     = 1'b0;
          w_busy_d    = 1'b1;
          w_ready_d   = 1'b0;
          w_hdr_d     = {bus.port_sel, bus.len};
          w_len_d     = bus.len;
          w_piso_load = 1'b1;
        end
      end
      StStart: begin
        if (bus.bit_en) begin
          w_state_d = StPort;
          w_ser_d   = w_hdr_msb;
          w_hdr_d   = r_hdr << 1;
          w_cnt_d   = PortLast;
        end
      end
      StPort: begin
        if (bus.bit_en) begin
          w_ser_d = w_hdr_msb;
          w_hdr_d = r_hdr << 1;
          if (r_cnt == '0) begin
            w_state_d = StLen;
            w_cnt_d   = LenLast;
          end else begin
            w_cnt_d = r_cnt - CntOne;
          end
        end
      end
      StLen: begin
        if (bus.bit_en) begin
          if (r_cnt != '0) begin
            w_ser_d = w_hdr_msb;
            w_hdr_d = r_hdr << 1;
            w_cnt_d = r_cnt - CntOne;
          end else if (r_len != '0) begin
            w_state_d    = StData;
            w_ser_d      = w_piso_bit;
            w_piso_shift = 1'b1;
            w_cnt_d      = CntW'(r_len - LenOne);
          end else begin
            w_state_d = StGap;
            w_ser_d   = IdleLevel;
          end
        end
      end
      StData: begin
        if (bus.bit_en) begin
          if (r_cnt == '0) begin
            w_state_d = StGap;
            w_ser_d   = IdleLevel;
          end else begin
            w_ser_d      = w_piso_bit;
            w_piso_shift = 1'b1;
            w_cnt_d      = r_cnt - CntOne;
          end
        end
      end
      StGap: begin
        if (bus.bit_en) begin
          w_state_d = StIdle;
          w_ser_d   = IdleLevel;
          w_busy_d  = 1'b0;
          w_ready_d = 1'b1;
          w_done_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_ser_d   = IdleLevel;
        w_busy_d  = 1'b0;
        w_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.ser_out    = r_ser;
  assign bus.ready      = r_ready;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_mssd_frame_gen.sv
// Scoreboard bench for mssd_frame_gen: directed frames push expected line bits, a monitor
// compares them at every receiver sampling point.
module tb_mssd_frame_gen;
  import mssd_frame_gen_pkg::*;

  localparam int unsigned PW = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned DW = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mssd_frame_gen_if #(.PORT_W(PW), .LEN_W(LW), .DATA_W(DW)) bus ();

  mssd_frame_gen #(
    .PORT_W (PW),
    .LEN_W  (LW),
    .DATA_W (DW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];
  int len_q[$];
  int bits_seen = 0;
  int frames_done = 0;
  int en_div = 3;
  int cyc = 0;
  bit eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // bit_en strobe: every en_div-th cycle, or every cycle when en_div is 1.
  initial begin
    bus.bit_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.bit_en = (en_div <= 1) || (cyc % en_div == 0);
    end
  end

  // The receiver samples ser_out at each bit_en edge while a frame is in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bit_en && bus.busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_bit: got %0b, expected no bit", bus.ser_out);
        end else begin
          eb = exp_q.pop_front();
          check($sformatf("bit%0d", bits_seen), {31'd0, bus.ser_out}, {31'd0, eb});
        end
        bits_seen++;
      end
      if (bus.frame_done) begin
        if (len_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got frame_done=1, expected 0");
        end else begin
          check("frame_len", bits_seen, len_q.pop_front());
        end
        check("ready_at_done", {31'd0, bus.ready}, 32'd1);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        bits_seen = 0;
        frames_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    len_q.push_back(n);
  endtask

  task automatic wait_ready(input int limit);
    int k = 0;
    while (!bus.ready && k < limit) begin
      tick();
      k++;
    end
    check("ready_timeout", {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [LW-1:0] l, input logic [DW-1:0] d);
    wait_ready(200);
    bus.port_sel = p;
    bus.len      = l;
    bus.payload  = d;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    // Scramble fields after accept: the frame must come from the latched copies.
    bus.port_sel = ~p;
    bus.len      = ~l;
    bus.payload  = ~d;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (len_q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check("frame_timeout", len_q.size(), 0);
  endtask

  task automatic wait_bits(input int n, input int limit);
    int k = 0;
    while (bits_seen < n && k < limit) begin
      tick();
      k++;
    end
    check("bits_timeout", {31'd0, bits_seen >= n}, 32'd1);
  endtask

  int saved_done;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.port_sel = '0;
    bus.len      = '0;
    bus.payload  = '0;
    #12;
    check("rst_ser", {31'd0, bus.ser_out}, 32'd1);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.frame_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // port 10, len 3, payload ...0101 (upper bits must not be sent)
    push_frame(32'b0_10_0011_101_1, 11);
    send(2'b10, 4'd3, 15'h7FF5);
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    check("ready_after_accept", {31'd0, bus.ready}, 32'd0);
    check("start_bit_level", {31'd0, bus.ser_out}, 32'd0);
    wait_done(400);

    // len 0: header plus gap only
    push_frame(32'b0_01_0000_1, 8);
    send(2'b01, 4'd0, 15'h7FFF);
    wait_done(400);

    // maximum length, alternating payload
    push_frame(32'b0_11_1111_101010101010101_1, 23);
    send(2'b11, 4'd15, 15'h5555);
    wait_done(400);

    // start pulsed during DATA is ignored
    push_frame(32'b0_01_0010_01_1, 10);
    send(2'b01, 4'd2, 15'h0002);
    wait_bits(8, 200);
    bus.port_sel = 2'b11;
    bus.len      = 4'd15;
    bus.payload  = '1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_start_ignored", {31'd0, bus.busy}, 32'd1);
    wait_done(400);

    // asynchronous reset mid-DATA
    saved_done = frames_done;
    push_frame(32'b0_11_1111_101010101010101_1, 23);
    send(2'b11, 4'd15, 15'h5555);
    wait_bits(10, 300);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ser", {31'd0, bus.ser_out}, 32'd1);
    check("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.frame_done}, 32'd0);
    exp_q.delete();
    len_q.delete();
    bits_seen = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("no_done_after_rst", frames_done, saved_done);

    // start accepted on a bit_en cycle: start bit still lasts one full period
    push_frame(32'b0_10_0001_0_1, 9);
    wait_ready(200);
    begin
      int k = 0;
      while (!bus.bit_en && k < 20) begin
        tick();
        k++;
      end
    end
    bus.port_sel = 2'b10;
    bus.len      = 4'd1;
    bus.payload  = 15'h0000;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("coinc_start_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check("coinc_start_held", {31'd0, bus.ser_out}, 32'd0);
    wait_done(400);

    // bit_en every cycle, start held: back-to-back frames
    en_div = 1;
    push_frame(32'b0_00_0001_1_1, 9);
    push_frame(32'b0_00_0001_1_1, 9);
    wait_ready(200);
    saved_done   = frames_done;
    bus.port_sel = 2'b00;
    bus.len      = 4'd1;
    bus.payload  = 15'h0001;
    bus.start    = 1'b1;
    tick();
    check("b2b_first_accept", {31'd0, bus.busy}, 32'd1);
    begin
      int k = 0;
      while (frames_done == saved_done && k < 100) begin
        tick();
        k++;
      end
    end
    check("b2b_second_accept", {31'd0, bus.busy}, 32'd1);
    check("b2b_second_start", {31'd0, bus.ser_out}, 32'd0);
    bus.start = 1'b0;
    wait_done(400);
    repeat (4) tick();
    check("b2b_idle_after", {31'd0, bus.ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
